// File: rtl/mem_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_if : one core load/store -> one handshaked data-bus transaction.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module mem_bus_if #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err,
  output logic [XLEN-1:0] DAD,
  output logic            MREQ,
  output logic            WRITE,
  output logic [1:0]      SIZE,
  input  logic            ACKD_n,
  input  logic [XLEN-1:0] ddt_in,
  output logic [XLEN-1:0] ddt_out,
  output logic            ddt_oe
);

  localparam int AL = $clog2(XLEN/8);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          wait_cnt;
  logic                   ld_unsigned;
  logic                   aligned;
  logic                   accept;
  logic [XLEN-1:0]        wdata_rep;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        left;
  logic [XLEN-1:0]        ld_ext;
  logic signed [XLEN-1:0] ld_sext;
  logic [6:0]             pad;

  assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    aligned = 1'b0;
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (XLEN == 64) && (req_addr[AL-1:0] == '0);
    endcase
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      2'b00:   wdata_rep = {(XLEN/8){req_wdata[7:0]}};
      2'b01:   wdata_rep = {(XLEN/16){req_wdata[15:0]}};
      2'b10:   wdata_rep = {(XLEN/32){req_wdata[31:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Right-justify the addressed lane, then extend by shifting the field to the MSB and back.
  always_comb begin
    pad = 7'd0;
    case (SIZE)
      2'b00:   pad = 7'(XLEN - 8);
      2'b01:   pad = 7'(XLEN - 16);
      2'b10:   pad = 7'(XLEN - 32);
      default: pad = 7'd0;
    endcase
    shifted = ddt_in >> {DAD[AL-1:0], 3'b000};
    left    = shifted << pad;
    ld_sext = $signed(left) >>> pad;
    ld_ext  = ld_unsigned ? (left >> pad) : ld_sext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ld_unsigned <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 2'b00;
      resp_rdata  <= '0;
      DAD         <= '0;
      MREQ        <= 1'b0;
      WRITE       <= 1'b0;
      SIZE        <= 2'b00;
      ddt_out     <= '0;
      ddt_oe      <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        BUS: begin
          if (!ACKD_n) begin
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            ddt_oe     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 2'b00;
            resp_rdata <= WRITE ? '0 : ld_ext;
            state      <= RESP;
          end else if ((TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1))) begin
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            ddt_oe     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 2'b10;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new acceptance (from IDLE or back-to-back from RESP) overrides the above.
      if (accept) begin
        if (aligned) begin
          DAD         <= req_addr;
          SIZE        <= req_size;
          WRITE       <= req_we;
          ddt_oe      <= req_we;
          ddt_out     <= wdata_rep;
          ld_unsigned <= req_unsigned;
          MREQ        <= 1'b1;
          wait_cnt    <= '0;
          resp_valid  <= 1'b0;
          state       <= BUS;
        end else begin
          resp_valid  <= 1'b1;
          resp_err    <= 2'b01;
          resp_rdata  <= '0;
          state       <= RESP;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_if : directed table, random transactions and corner sequences.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_mem_bus_if;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic            resp_valid, resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic [1:0]      resp_err;
  logic [XLEN-1:0] DAD;
  logic            MREQ, WRITE;
  logic [1:0]      SIZE;
  logic            ACKD_n;
  logic [XLEN-1:0] ddt_in, ddt_out;
  logic            ddt_oe;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_if #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .ddt_in(ddt_in),
    .ddt_out(ddt_out), .ddt_oe(ddt_oe)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          a;      // MREQ-high cycle in which ACKD_n is driven low
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] dout;
    int          mreq;   // expected number of MREQ-high cycles
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] bus, input int a, input logic [1:0] err,
                              input logic [31:0] rd, input logic [31:0] dout, input int mreq);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.bus = bus;
    v.a = a; v.err = err; v.rdata = rd; v.dout = dout; v.mreq = mreq;
    return v;
  endfunction

  // Reference: little-endian lanes, replicated stores, extended loads, timeout after TO cycles.
  function automatic vec_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] bus, input int a);
    vec_t v;
    longint unsigned mask, val;
    int bits, lane;
    v = mk(we, sz, uns, addr, wdata, bus, a, 2'b00, 32'h0, 32'h0, 0);
    bits = 8 << sz;
    mask = (64'd1 << bits) - 64'd1;
    if (sz == 2'd3 || (addr % (32'd1 << sz)) != 0) begin
      v.err = 2'b01;
      return v;
    end
    for (int i = 0; i < 32 / bits; i++)
      v.dout = v.dout | 32'((longint'(wdata) & mask) << (bits * i));
    lane = int'(addr % 4);
    val  = (longint'(bus) >> (8 * lane)) & mask;
    if (!uns && val[bits-1]) val = val | ~mask;
    v.rdata = we ? 32'h0 : 32'(val);
    if (a > TO) begin
      v.err = 2'b10; v.rdata = 32'h0; v.mreq = TO;
    end else begin
      v.mreq = a;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic ok;
    int   cyc;
    @(negedge clk);
    chk($sformatf("%s req_ready", tag), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b1; cyc = 0;
    for (int t = 0; t < 16 && MREQ === 1'b1; t++) begin
      cyc++;
      if (DAD !== v.addr || SIZE !== v.size || WRITE !== v.we || ddt_oe !== v.we ||
          resp_valid !== 1'b0 || (v.we && ddt_out !== v.dout)) ok = 1'b0;
      ACKD_n = (cyc == v.a) ? 1'b0 : 1'b1;
      ddt_in = v.bus;
      @(negedge clk);
      ACKD_n = 1'b1;
    end
    ddt_in = $urandom;
    chk($sformatf("%s bus_fields", tag), 32'(ok), 32'd1);
    chk($sformatf("%s mreq_cycles", tag), 32'(cyc), 32'(v.mreq));
    chk($sformatf("%s resp_valid", tag), 32'(resp_valid), 32'd1);
    chk($sformatf("%s resp_err", tag), 32'(resp_err), 32'(v.err));
    chk($sformatf("%s resp_rdata", tag), resp_rdata, v.rdata);
    chk($sformatf("%s bus_idle", tag), {30'd0, MREQ, ddt_oe}, 32'd0);
    ACKD_n = 1'b0;                       // stray ack while holding the response
    @(negedge clk);
    ACKD_n = 1'b1;
    chk($sformatf("%s hold", tag), {resp_rdata[30:0] ^ v.rdata[30:0], resp_valid}, 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("%s consumed", tag), {30'd0, resp_valid, MREQ}, 32'd0);
  endtask

  task automatic stray_ack_idle();
    logic ok;
    ok = 1'b1;
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (MREQ !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
    end
    ACKD_n = 1'b1;
    chk("stray_ack_idle", 32'(ok), 32'd1);
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; ACKD_n = 1'b1; ddt_in = '0;

    //            we  sz     uns  addr      wdata         bus           a  err    rdata         dout         mreq
    tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        32'h8000_00FF, 3, 2'd0, 32'h8000_00FF, 32'h0,        3);
    tbl[1]  = mk(0, 2'd0, 0, 32'h103, 32'h0,        32'h8012_3456, 1, 2'd0, 32'hFFFF_FF80, 32'h0,        1);
    tbl[2]  = mk(0, 2'd0, 1, 32'h103, 32'h0,        32'h8012_3456, 2, 2'd0, 32'h0000_0080, 32'h0,        2);
    tbl[3]  = mk(1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 32'h0,        2, 2'd0, 32'h0,         32'hABCD_ABCD, 2);
    tbl[4]  = mk(0, 2'd2, 0, 32'h101, 32'h0,        32'h0,         1, 2'd1, 32'h0,         32'h0,        0);
    tbl[5]  = mk(0, 2'd2, 0, 32'h104, 32'h0,        32'h1234_5678, 9, 2'd2, 32'h0,         32'h0,        4);
    tbl[6]  = mk(0, 2'd1, 0, 32'h102, 32'h0,        32'h9ABC_1234, 4, 2'd0, 32'hFFFF_9ABC, 32'h0,        4);
    tbl[7]  = mk(0, 2'd1, 1, 32'h100, 32'h0,        32'h9ABC_8001, 1, 2'd0, 32'h0000_8001, 32'h0,        1);
    tbl[8]  = mk(1, 2'd0, 0, 32'h301, 32'hDEAD_BE5A, 32'h0,        1, 2'd0, 32'h0,         32'h5A5A_5A5A, 1);
    tbl[9]  = mk(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D, 32'h0,        3, 2'd0, 32'h0,         32'hCAFE_F00D, 3);
    tbl[10] = mk(0, 2'd3, 0, 32'h000, 32'h0,        32'h0,         1, 2'd1, 32'h0,         32'h0,        0);
    tbl[11] = mk(0, 2'd1, 0, 32'h203, 32'h0,        32'h0,         1, 2'd1, 32'h0,         32'h0,        0);
    tbl[12] = mk(0, 2'd0, 0, 32'h101, 32'h0,        32'h0000_7F00, 1, 2'd0, 32'h0000_007F, 32'h0,        1);

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'd0, MREQ, WRITE, ddt_oe, resp_valid, resp_err}, 32'd0);
    chk("reset_dad", DAD, 32'h0);
    chk("reset_ddt_out", ddt_out, 32'h0);
    chk("reset_rdata_size", {resp_rdata[29:0], SIZE}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      if (i == 5) stray_ack_idle();
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = 32'h400 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      rv = model(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom,
                 $urandom_range(1, TO + 2));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Back-to-back acceptance from RESP, then reset while the second is on the bus.
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h500; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_first_mreq", 32'(MREQ), 32'd1);
    req_we = 1'b1; req_addr = 32'h504; req_wdata = 32'h5555_AAAA;
    ACKD_n = 1'b0; ddt_in = 32'h1122_3344;
    @(negedge clk);
    ACKD_n = 1'b1;
    chk("b2b_gap", {29'd0, MREQ, resp_valid, req_ready}, 32'd3);
    chk("b2b_first_rdata", resp_rdata, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_bus", {29'd0, MREQ, WRITE, resp_valid}, 32'd6);
    chk("b2b_second_dad", DAD, 32'h504);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_bus", {29'd0, MREQ, ddt_oe, resp_valid}, 32'd0);
    begin
      logic ok;
      ok = 1'b1;
      ACKD_n = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (MREQ !== 1'b0 || resp_valid !== 1'b0) ok = 1'b0;
      end
      ACKD_n = 1'b1;
      chk("rst_no_resp", 32'(ok), 32'd1);
    end
    resp_ready = 1'b0;
    run_txn(tbl[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
